clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 109 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: wakes a shared gated clock on request, grants per-requester acks once settled,
// holds the clock after the last request and enforces a minimum off time. All outputs registered.
module clk_gate_ctrl #(
  parameter int N_REQ       = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int MIN_OFF     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             gate_en_n,
  output logic             gate_active
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] MIN_OFF_V = 8'(MIN_OFF);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [7:0]       r_off_cnt;
  logic [N_REQ-1:0] r_ack;
  logic             r_gate_en_n;
  logic             r_gate_active;
  logic             w_any_req;

  assign w_any_req   = |req;
  assign ack         = r_ack;
  assign gate_en_n   = r_gate_en_n;
  assign gate_active = r_gate_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_OFF;
      r_cnt         <= 8'd0;
      r_off_cnt     <= MIN_OFF_V;
      r_ack         <= '0;
      r_gate_en_n   <= 1'b1;
      r_gate_active <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (r_off_cnt != 8'hFF) begin
            r_off_cnt <= r_off_cnt + 8'd1;
          end
          if (w_any_req && (r_off_cnt >= MIN_OFF_V)) begin
            r_state       <= ST_WAKE;
            r_cnt         <= WAKE_LOAD;
            r_gate_en_n   <= 1'b0;
            r_gate_active <= 1'b1;
          end
        end
        ST_WAKE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (w_any_req) begin
            r_state <= ST_ON;
            r_ack   <= req;
          end else begin
            // Requester went away while settling: fall into the hold window.
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LOAD;
          end
        end
        ST_ON: begin
          if (w_any_req) begin
            r_ack <= req;
          end else if (HOLD_CYCLES == 0) begin
            r_state       <= ST_OFF;
            r_ack         <= '0;
            r_off_cnt     <= 8'd0;
            r_gate_en_n   <= 1'b1;
            r_gate_active <= 1'b0;
          end else begin
            r_state <= ST_HOLD;
            r_ack   <= '0;
            r_cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (w_any_req) begin
            r_state <= ST_ON;
            r_ack   <= req;
          end else if (r_cnt == 8'd0) begin
            r_state       <= ST_OFF;
            r_off_cnt     <= 8'd0;
            r_gate_en_n   <= 1'b1;
            r_gate_active <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed scoreboard bench for clk_gate_ctrl with default parameters.
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic       gate_en_n;
  logic       gate_active;

  int total;
  int bad;

  typedef struct packed {
    logic       rst_n;
    logic [3:0] req;
    logic       gen;
    logic [3:0] ack;
    logic       act;
  } vec_t;

  typedef struct packed {
    logic       gen;
    logic [3:0] ack;
    logic       act;
  } exp_t;

  vec_t stim[$];
  exp_t sb[$];

  clk_gate_ctrl #(
    .N_REQ(4), .WAKE_CYCLES(2), .HOLD_CYCLES(8), .MIN_OFF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gate_en_n(gate_en_n), .gate_active(gate_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Queue n cycles of stimulus with the outputs expected after each edge.
  task automatic add(input int n, input logic r, input logic [3:0] rq,
                     input logic g, input logic [3:0] a, input logic act);
    vec_t v;
    v = '{rst_n: r, req: rq, gen: g, ack: a, act: act};
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'hF;

    // Reset held with all requests high
    add(3, 0, 4'hF, 1, 4'h0, 0);
    // First released edge starts WAKE; ack two edges later
    add(1, 1, 4'hF, 0, 4'h0, 1);
    add(1, 1, 4'h1, 0, 4'h0, 1);
    add(1, 1, 4'h1, 0, 4'h1, 1);
    // Multi-requester in ON, one-cycle lag
    add(1, 1, 4'h5, 0, 4'h5, 1);
    add(1, 1, 4'h4, 0, 4'h4, 1);
    // Hold re-arm at j+5
    add(5, 1, 4'h0, 0, 4'h0, 1);
    add(1, 1, 4'h2, 0, 4'h2, 1);
    // Hold expiry at j+8, then minimum off time before the next wake
    add(8, 1, 4'h0, 0, 4'h0, 1);
    add(1, 1, 4'h0, 1, 4'h0, 0);
    add(2, 1, 4'h8, 1, 4'h0, 0);
    add(2, 1, 4'h8, 0, 4'h0, 1);
    add(1, 1, 4'h8, 0, 4'h8, 1);
    // Back to OFF and let off_cnt pass MIN_OFF
    add(8, 1, 4'h0, 0, 4'h0, 1);
    add(3, 1, 4'h0, 1, 4'h0, 0);
    // Enter WAKE, then reset one edge later: no ack ever
    add(1, 1, 4'h1, 0, 4'h0, 1);
    add(3, 0, 4'h1, 1, 4'h0, 0);
    // Release with pending req: immediate WAKE; drop req so WAKE falls to HOLD
    add(1, 1, 4'h1, 0, 4'h0, 1);
    add(2, 1, 4'h0, 0, 4'h0, 1);
    // Request from HOLD returns straight to ON
    add(1, 1, 4'h3, 0, 4'h3, 1);
    add(1, 1, 4'h0, 0, 4'h0, 1);

    while (stim.size() > 0) begin
      @(negedge clk);
      v     = stim.pop_front();
      rst_n = v.rst_n;
      req   = v.req;
      sb.push_back('{gen: v.gen, ack: v.ack, act: v.act});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("gate_en_n@%0d", total / 3), {31'd0, gate_en_n}, {31'd0, e.gen});
        check($sformatf("ack@%0d", total / 3), {28'd0, ack}, {28'd0, e.ack});
        check($sformatf("gate_active@%0d", total / 3), {31'd0, gate_active}, {31'd0, e.act});
      end
    end
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
